pwm_sample_decoder: RTL and testbench

- Receive-side counterpart of the comparator-based PWM generator in the ANC output path.
- Measures the high time of an incoming PWM waveform over one fixed-length frame and reconstructs the 7-bit sample that produced it.
- Used for loopback checking of the anti-noise output and for capturing PWM-coded sensor inputs into the ANC datapath.

---
 rtl/pwm_sample_decoder.sv | 191 +++++++++++++++++++
 tb/tb_pwm_sample_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_decoder.sv
// -----------------------------------------------------------------------------
// pwm_sample_decoder
//
// Receive-side PWM decoder. It measures how many ticks an incoming PWM waveform
// is high during one frame of 2^W ticks, and from that count it rebuilds the
// W-bit sample that produced the waveform. Frames are locked to the first
// rising edge that arrives while the decoder is enabled. After that, frames
// follow one another with no gap. A rising edge that arrives away from a frame
// boundary discards the current partial frame and starts a new frame on that
// edge.
//
// Optional build macro:
//   PWM_GLITCH_FILT_EN - adds a 3-tap majority filter, clocked by tick_en,
//                        between the synchroniser and the edge detector /
//                        high counter. It rejects single-tick glitches and
//                        adds one tick of latency.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick_en      in   PWM tick strobe; all frame counting advances only on it
//   pwm_in       in   asynchronous PWM waveform
//   enable       in   decoder enable; 0 forces IDLE
//   sample       out  [W-1:0] last decoded high-tick count
//   sample_valid out  one-clock pulse when sample updates
//   sat          out  frame was high for all 2^W ticks (sample clipped)
//   sync_err     out  one-clock pulse on a misaligned rising edge
//   locked       out  high while measuring
//
// States:
//   ST_IDLE    | waiting for an enabled rising edge; counters held at 0
//   ST_MEASURE | counting ticks of back-to-back frames
// -----------------------------------------------------------------------------
module pwm_sample_decoder #(
  parameter int W           = 7,
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_en,
  input  logic         pwm_in,
  input  logic         enable,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         sat,
  output logic         sync_err,
  output logic         locked
);

  typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

  localparam logic [W-1:0] LAST_TICK = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_f;
  logic                   prev_q;
  logic                   rise;
  logic [W-1:0]           period_q, period_d;
  logic [W:0]             high_q, high_d;
  logic [W:0]             high_inc;
  logic [W-1:0]           sample_q, sample_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Input synchroniser. It always clocks, independent of tick_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILT_EN
  // Majority of the current and the two previous tick samples. A single-tick
  // pulse never wins the vote. Clean edges come out delayed by exactly one tick.
  logic [1:0] tap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else if (tick_en) begin
      tap_q <= {tap_q[0], pwm_s};
    end
  end

  assign pwm_f = (pwm_s & tap_q[0]) | (pwm_s & tap_q[1]) | (tap_q[0] & tap_q[1]);
`else
  assign pwm_f = pwm_s;
`endif

  // The edge-detect history advances on ticks only, so a rising edge is seen
  // on exactly one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (tick_en) begin
      prev_q <= pwm_f;
    end
  end

  assign rise     = pwm_f & ~prev_q;
  assign high_inc = high_q + {{W{1'b0}}, pwm_f};

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    sample_d = sample_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        high_d   = '0;
        // The edge tick is tick 0 of the frame, and it counts as high.
        if (enable && tick_en && rise) begin
          state_d  = ST_MEASURE;
          period_d = W'(1);
          high_d   = (W+1)'(1);
        end
      end

      ST_MEASURE: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          period_d = '0;
          high_d   = '0;
        end else if (tick_en) begin
          // An edge on the frame-start tick is expected. An edge on the
          // frame-end tick is accepted as well: that frame finishes normally.
          if (rise && (period_q != '0) && (period_q != LAST_TICK)) begin
            err_d    = 1'b1;
            period_d = W'(1);
            high_d   = (W+1)'(1);
          end else begin
            period_d = period_q + W'(1);
            if (period_q == LAST_TICK) begin
              valid_d  = 1'b1;
              sat_d    = high_inc[W];
              sample_d = high_inc[W] ? '1 : high_inc[W-1:0];
              high_d   = '0;
            end else begin
              high_d   = high_inc;
            end
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        period_d = '0;
        high_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      high_q   <= '0;
      sample_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      sample_q <= sample_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign sample       = sample_q;
  assign sat          = sat_q;
  assign sample_valid = valid_q;
  assign sync_err     = err_q;
  assign locked       = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for pwm_sample_decoder.
// A PWM generator drives frames of a chosen duty. For each frame, the bench
// records the clock cycle at which the decoder must report the result, and it
// stores the frame's high-tick count (or a sync_err) at that cycle. A monitor
// on the falling edge compares sample_valid, sample, sat and sync_err against
// this schedule on every clock cycle while reset is released.
// -----------------------------------------------------------------------------
module tb_pwm_sample_decoder;

  localparam int W = 7;
  localparam int N = 1 << W;
`ifdef PWM_GLITCH_FILT_EN
  localparam int FLAT = 1;
`else
  localparam int FLAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_en = 1'b0;
  logic         pwm_in = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] sample;
  logic         sample_valid;
  logic         sat;
  logic         sync_err;
  logic         locked;

  pwm_sample_decoder #(.W(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_en      (tick_en),
    .pwm_in       (pwm_in),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sat          (sat),
    .sync_err     (sync_err),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int slow   = 0;
  int exp_val [int];
  bit exp_err [int];
  int last_h       = 0;
  int last_vcyc    = -1;
  int last_vsample = -1;
  int last_vsat    = -1;
  int err_seen     = 0;

  function automatic int model_sample(input int h);
    return (h >= N) ? N - 1 : h;
  endfunction

  function automatic int model_sat(input int h);
    return (h >= N) ? 1 : 0;
  endfunction

  // A tick driven at cycle c is seen by the decoder after two synchroniser
  // clocks and is reported one clock later. The filter adds one tick.
  function automatic int lat();
    return 3 + FLAT * ((slow != 0) ? 4 : 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_err_exclusive", sample_valid & sync_err, 0);
      check("sample_valid", sample_valid, exp_val.exists(cyc));
      if (exp_val.exists(cyc)) begin
        last_h = exp_val[cyc];
        exp_val.delete(cyc);
      end
      check("sample", sample, model_sample(last_h));
      check("sat", sat, model_sat(last_h));
      check("sync_err", sync_err, exp_err.exists(cyc));
      if (exp_err.exists(cyc)) exp_err.delete(cyc);
      if (sample_valid) begin
        last_vcyc    = cyc;
        last_vsample = sample;
        last_vsat    = sat;
      end
      if (sync_err) err_seen++;
    end
  end

  task automatic step(input logic p, input logic te);
    @(posedge clk);
    #1;
    pwm_in  = p;
    tick_en = te;
  endtask

  // In slow mode, one tick spans 4 clocks and tick_en pulses 2 clocks after
  // pwm_in changes. In fast mode, tick_en is high on every clock.
  task automatic drive_tick(input logic p, output int c);
    if (slow != 0) begin
      step(p, 1'b0);
      c = cyc;
      step(p, 1'b0);
      step(p, 1'b1);
      step(p, 1'b0);
    end else begin
      step(p, 1'b1);
      c = cyc;
    end
  endtask

  // One generator frame. exp_h < 0: no sample expected. err_tick < 0: no sync_err.
  task automatic run_frame(input int duty, input int flip, input int dis,
                           input int exp_h, input int err_tick, output int c0);
    int   c;
    logic p;
    c0 = 0;
    for (int k = 0; k < N; k++) begin
      p = (k < duty);
      if (k == flip) p = ~p;
      if (k == dis) enable = 1'b0;
      drive_tick(p, c);
      if (k == 0) c0 = c;
      if (k == N - 1 && exp_h >= 0) exp_val[c + lat()] = exp_h;
      if (k == err_tick) exp_err[c + lat()] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t0;
    int dummy;

    #1;
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_sat", sat, 0);
    check("reset_sync_err", sync_err, 0);
    check("reset_locked", locked, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;
    slow   = 0;

    repeat (5) drive_tick(1'b0, c);
    check("idle_before_edge_locked", locked, 0);

    // 40/88 frames.
    run_frame(40, -1, -1, 40, -1, t0);
    check("locked_after_edge", locked, 1);
    run_frame(40, -1, -1, 40, -1, dummy);
    check("first_valid_latency", last_vcyc - t0, 130 + FLAT);
    check("first_sample_40", last_vsample, 40);
    run_frame(40, -1, -1, 40, -1, dummy);
    check("second_valid_period", last_vcyc - t0, 258 + FLAT);

    // Duty steps, including the all-low frame. Under the filter, a 1-tick
    // pulse is rejected as a glitch.
    run_frame(12, -1, -1, 12, -1, dummy);
    run_frame(1, -1, -1, (FLAT != 0) ? 0 : 1, -1, dummy);
    run_frame(13, -1, -1, 13, -1, dummy);
    run_frame(15, -1, -1, 15, -1, dummy);
    run_frame(0, -1, -1, 0, -1, dummy);
    check("duty15_sample", last_vsample, 15);

    // Held high for three frames.
    run_frame(N, -1, -1, N, -1, dummy);
    check("duty0_sample", last_vsample, 0);
    check("duty0_sat", last_vsat, 0);
    run_frame(N, -1, -1, N, -1, dummy);
    run_frame(N, -1, -1, N, -1, dummy);

    // 64-duty stream with an extra edge at tick 50. The resync at tick 50
    // means that the following generator frame start is also misaligned once.
    run_frame(64, -1, -1, 64, -1, dummy);
    check("allhigh_sample_127", last_vsample, 127);
    check("allhigh_sat", last_vsat, 1);
    check("allhigh_no_sync_err", err_seen, 0);
    if (FLAT != 0) begin
      run_frame(64, 49, -1, 64, -1, dummy);
      run_frame(64, -1, -1, 64, -1, dummy);
    end else begin
      run_frame(64, 49, -1, -1, 50, dummy);
      run_frame(64, -1, -1, 64, 0, dummy);
    end
    run_frame(64, -1, -1, 64, -1, dummy);
    check("misalign_err_count", err_seen, (FLAT != 0) ? 0 : 2);
    check("realigned_sample_64", last_vsample, 64);

    // 1-tick high glitch inside the low phase of a 20-duty frame.
    if (FLAT != 0) begin
      run_frame(20, 60, -1, 20, -1, dummy);
      run_frame(20, -1, -1, 20, -1, dummy);
    end else begin
      run_frame(20, 60, -1, -1, 60, dummy);
      run_frame(20, -1, -1, 20, 0, dummy);
    end

    // Enable dropped mid-frame: no sample, sample/sat hold.
    run_frame(20, -1, 80, -1, -1, dummy);
    check("disable_unlocks", locked, 0);
    check("disable_holds_sample", last_vsample, 20);
    check("glitch_err_count", err_seen, (FLAT != 0) ? 0 : 4);

    // Slow ticks (1 in 4) with an asynchronous reset in the middle of a frame.
    step(1'b0, 1'b0);
    rst_n  = 1'b0;
    last_h = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;
    slow   = 1;
    repeat (3) drive_tick(1'b0, c);
    run_frame(40, -1, -1, 40, -1, dummy);
    for (int k = 0; k <= 70; k++) drive_tick(k < 40, c);
    check("slow_sample_before_reset", sample, 40);
    check("slow_locked_before_reset", locked, 1);
    #2;
    rst_n  = 1'b0;
    last_h = 0;
    #1;
    check("midreset_sample", sample, 0);
    check("midreset_valid", sample_valid, 0);
    check("midreset_sat", sat, 0);
    check("midreset_sync_err", sync_err, 0);
    check("midreset_locked", locked, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 71; k < N; k++) drive_tick(1'b0, c);
    check("post_reset_idle", locked, 0);
    run_frame(40, -1, -1, 40, -1, dummy);
    repeat (2) drive_tick(1'b0, c);
    check("post_reset_sample", last_vsample, 40);
    check("post_reset_locked", locked, 1);

    check("pending_events", exp_val.num() + exp_err.num(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
